// File: rtl/mem_data_router_if.sv
// ---------------------------------------------------------------------------
// mem_data_router_if
//   Bundles the signals between the memory read-data port, the router and
//   its consumers.
//   Input side : in_valid, in_ready, in_sel, in_data (valid/ready word stream
//                with a destination tag).
//   Output side: out_valid, out_ready, out_data (one valid/ready lane per
//                channel, channel c data at bits [c*WIDTH +: WIDTH]).
//   Status     : drop_cnt, saturating count of words whose tag names no
//                existing channel.
//   Modports   : master = producer/consumer environment, slave = router.
// ---------------------------------------------------------------------------
interface mem_data_router_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [WIDTH-1:0]          in_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [7:0]                drop_cnt;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
endinterface

// File: rtl/mem_data_router.sv
// ---------------------------------------------------------------------------
// mem_data_router
//   Steers each memory read word to one of CHANNELS consumers using its
//   select tag. Every channel owns a DEPTH-entry FIFO, so one stalled
//   consumer only back-pressures words addressed to it. Words tagged with a
//   non-existent channel are accepted, discarded and counted.
//   Ports:
//     clk   - clock, all state updates on the rising edge
//     rst_n - asynchronous active-low reset (clears FIFO state and drop_cnt)
//     bus   - mem_data_router_if.slave: input stream, per-channel output
//             streams and the drop counter
// ---------------------------------------------------------------------------
module mem_data_router #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1,
    parameter int DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_data_router_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q    [CHANNELS][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0] wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_d [CHANNELS];
    logic [CNT_W-1:0] count_q  [CHANNELS];
    logic [CNT_W-1:0] count_d  [CHANNELS];
    logic [7:0]       drop_q;
    logic [7:0]       drop_d;

    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic                sel_hit;
    logic                drop;

    // Handshake decode. in_ready looks only at the addressed FIFO's fill
    // level, never at out_ready, so a full FIFO refuses a word even in the
    // cycle its consumer pops.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        full         = '0;
        valid        = '0;
        push         = '0;
        pop          = '0;
        sel_hit      = 1'b0;
        bus.in_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            full[c]  = (count_q[c] == CNT_W'(DEPTH));
            valid[c] = (count_q[c] != '0);
            pop[c]   = valid[c] && bus.out_ready[c];
            if (bus.in_sel == SEL_W'(c)) begin
                sel_hit      = 1'b1;
                bus.in_ready = !full[c];
                push[c]      = bus.in_valid && !full[c];
            end
        end
        // Out-of-range tags are always accepted and thrown away.
        drop = bus.in_valid && !sel_hit;
    end

    // Next-state: pointers wrap naturally because DEPTH is a power of two;
    // a push to an empty FIFO is not a pop because valid was still low.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
            count_d[c]  = count_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
        end
        drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            drop_q <= drop_d;
        end
    end

    // NOTE: the storage array has no reset; zero counts already mark every
    // entry as empty, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= bus.in_data;
            end
        end
    end

    // Head words are read straight out of storage through the rd_ptr mux;
    // an empty channel presents zeros rather than stale data.
    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (valid[c]) begin
                bus.out_data[c*WIDTH +: WIDTH] = mem_q[c][rd_ptr_q[c]];
            end
        end
    end

    assign bus.out_valid = valid;
    assign bus.drop_cnt  = drop_q;

endmodule

// File: doc/mem_data_router.md
# mem_data_router

Clocked, parametrised memory read-data router. Steers each word returned by the memory interface to one of CHANNELS consumers (channel 0 = instruction fetch, channel 1 = data cache by default) using a select tag. Each channel has its own DEPTH-entry FIFO, so a stalled consumer does not block the others until its own FIFO fills. Sits between the memory data port and the instruction/cache front ends and adds valid/ready flow control and drop accounting.

## Interface
- WIDTH, 16, data word width in bits
- CHANNELS, 2, number of output channels (≥2)
- SEL_W, 1, select tag width; 2^SEL_W ≥ CHANNELS required
- DEPTH, 4, entries per channel FIFO; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  router accepts word this cycle
- in_sel  in  SEL_W  destination channel tag
- in_data  in  WIDTH  input word
- out_valid  out  CHANNELS  bit c: channel c head word valid
- out_ready  in  CHANNELS  bit c: consumer c takes head word
- out_data  out  CHANNELS*WIDTH  channel c word at bits [c*WIDTH +: WIDTH]
- drop_cnt  out  8  number of words dropped for out-of-range in_sel, saturating

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out on channel c: out_valid[c] && out_ready[c].
- in_sel < CHANNELS: in_ready = !full[in_sel]; on transfer, in_data is written at wr_ptr[in_sel], wr_ptr increments, count increments.
- in_sel ≥ CHANNELS: in_ready = 1; word accepted and discarded; drop_cnt increments, saturating at 255 (no wrap).
- in_ready is a function of in_sel and FIFO state only; it has no combinational dependency on out_ready. A full FIFO refuses input even in the cycle its consumer pops.
- Per channel: out_valid[c] = (count[c] != 0); out_data slice = mem[c][rd_ptr[c]] when valid, else all zeros.
- Pop: rd_ptr increments, count decrements.
- Simultaneous push and pop on the same non-empty, non-full channel: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap DEPTH-1 → 0. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Empty channel: a push and an out_ready in the same cycle is not a pop (out_valid=0); the word becomes visible next cycle.
- Channels are fully independent; per-channel order is FIFO. No ordering is guaranteed across channels.
- in_sel and in_data must be stable while in_valid=1 and in_ready=0. Changing them is not checked; the router evaluates in_ready against the current in_sel.

## Timing
- Reset (rst_n=0, asynchronous): all counts 0, pointers 0, drop_cnt 0 → out_valid=0, out_data=0, in_ready=1 for any in_sel. FIFO storage is not reset.
- Reset asserted mid-operation: all buffered words are lost immediately. No transfer occurs in a cycle where rst_n is low at the edge.
- Latency: word accepted at edge N is presented on out_valid/out_data after edge N (usable for pop at edge N+1). Latency is 1 cycle, no bypass.
- Throughput: one input word per cycle. Each channel sustains one pop per cycle.
- Full: count=DEPTH → in_ready=0 for that sel. Becomes 1 in the cycle after a pop.
- out_data is a registered-memory read through the rd_ptr mux. It changes only after an edge.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, release. Required: out_valid=2'b00, out_data=0, drop_cnt=0, in_ready=1 for in_sel=0 and 1.
- Routing and latency: push 16'hA5A5 with sel=0, then 16'h5A5A with sel=1, out_ready=2'b11. Required: each appears on its own channel exactly one cycle after acceptance; the other channel stays invalid.
- Full/wrap: out_ready[0]=0; push 0x0001..0x0005 to ch0 (DEPTH=4). Required: first four accepted, in_ready=0 on the fifth; ch1 still accepts. Then assert out_ready[0] and push 0x0005..0x0008. Required: pops in order 0x0001..0x0008 across pointer wrap, no loss or duplication.
- Simultaneous push/pop: with ch0 holding 2 words, push and pop every cycle for 10 cycles. Required: count stays 2, order preserved.
- Drop: CHANNELS=3, SEL_W=2, push 300 words with sel=3. Required: in_ready=1 throughout, no out_valid, drop_cnt=255 (saturated).
- Reset mid-operation: fill ch1 with 3 words, pulse rst_n low between edges. Required: out_valid clears immediately, and the next push to ch1 is the first word out.
